// File: rtl/pipe_stage_chain.sv
// Chain of STAGES pipeline registers with valid/ready handshake, per-stage stall
// (bubble insertion) and per-stage flush; every stage is exposed for hazard logic.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          in_valid_i,
  input  logic [WIDTH-1:0]              in_data_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic [WIDTH-1:0]              out_data_o,
  input  logic                          out_ready_i,
  input  logic [STAGES-1:0]             stall_i,
  input  logic [STAGES-1:0]             flush_i,
  output logic [STAGES-1:0]             stage_valid_o,
  output logic [STAGES*WIDTH-1:0]       stage_data_o,
  output logic [$clog2(STAGES+1)-1:0]   occupancy_o
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  logic [STAGES-1:0] ev, go, load;
  logic              run, take;

  // Handshake resolves from the output end backwards: a stage may move only if
  // the stage after it loads this cycle, which allows full-rate flow when full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    run  = start_i & rst_i;
    ev   = valid_q & ~flush_i;
    go   = '0;
    load = '0;

    out_valid_o       = run & ev[STAGES-1] & ~stall_i[STAGES-1];
    take              = out_valid_o & out_ready_i;
    go[STAGES-1]      = take;
    load[STAGES-1]    = run & ~stall_i[STAGES-1] & (~ev[STAGES-1] | go[STAGES-1]);
    for (int k = STAGES-2; k >= 0; k--) begin
      go[k]   = ev[k] & ~stall_i[k] & load[k+1];
      load[k] = run & ~stall_i[k] & (~ev[k] | go[k]);
    end
    in_ready_o = load[0];
  end

  // A stage that does not load keeps its data; its valid bit still honours flush.
  always_comb begin
    valid_d = ev;
    for (int k = 0; k < STAGES; k++) data_d[k] = data_q[k];

    if (load[0]) begin
      valid_d[0] = in_valid_i;
      if (in_valid_i) data_d[0] = in_data_i;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = go[k-1];
        if (go[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    if (!rst_i) begin
      valid_q <= '0;
      // NOTE: payload registers are cleared too, so exposed stage data is never X.
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  always_comb begin
    stage_valid_o = valid_q;
    out_data_o    = data_q[STAGES-1];
    stage_data_o  = '0;
    occupancy_o   = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_data_o[k*WIDTH +: WIDTH] = data_q[k];
      occupancy_o = occupancy_o + OCC_W'(valid_q[k]);
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4, WIDTH=32): reset, streaming,
// backpressure, stall bubble, flush and freeze, with an expected-order queue.
module tb_pipe_stage_chain;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic                        clk_i;
  logic                        rst_i;
  logic                        start_i;
  logic                        in_valid_i;
  logic [WIDTH-1:0]            in_data_i;
  logic                        in_ready_o;
  logic                        out_valid_o;
  logic [WIDTH-1:0]            out_data_o;
  logic                        out_ready_i;
  logic [STAGES-1:0]           stall_i;
  logic [STAGES-1:0]           flush_i;
  logic [STAGES-1:0]           stage_valid_o;
  logic [STAGES*WIDTH-1:0]     stage_data_o;
  logic [$clog2(STAGES+1)-1:0] occupancy_o;

  pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .out_ready_i   (out_ready_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .stage_valid_o (stage_valid_o),
    .stage_data_o  (stage_data_o),
    .occupancy_o   (occupancy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          checks;
  int          failures;
  int          idle_cnt;
  bit          delivered_any;
  logic [31:0] next_in;
  logic [31:0] last_item;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sd(input int k);
    return stage_data_o[k*WIDTH +: WIDTH];
  endfunction

  task automatic begin_scn(input logic [31:0] first, input logic [31:0] last);
    next_in       = first;
    last_item     = last;
    idle_cnt      = 0;
    delivered_any = 1'b0;
  endtask

  // Offer the next item (if any remain) and let combinational outputs settle.
  task automatic drive();
    in_valid_i = (next_in <= last_item);
    in_data_i  = next_in;
    #2;
  endtask

  // Score this cycle's transfers, then advance past the next rising edge.
  task automatic finish_cycle();
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) check("spurious_out", out_data_o, 32'hFFFF_FFFF);
      else check("order", out_data_o, exp_q.pop_front());
      delivered_any = 1'b1;
    end else if (delivered_any && out_ready_i && exp_q.size() > 0) begin
      idle_cnt++;
    end
    if (in_valid_i && in_ready_o) begin
      exp_q.push_back(in_data_i);
      next_in++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && next_in > last_item && occupancy_o == '0) break;
      drive();
      finish_cycle();
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_occ", 32'(occupancy_o), 32'd0);
    check("drain_fed", next_in, last_item + 32'd1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_i       = 1'b0;
    start_i     = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hDEAD;
    out_ready_i = 1'b1;
    stall_i     = '0;
    flush_i     = '0;
    begin_scn(32'd1, 32'd0);

    // Reset held for two edges with input offered
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("rst_stage_valid", 32'(stage_valid_o), 32'd0);
    check("rst_occ", 32'(occupancy_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    for (int k = 0; k < STAGES; k++) check("rst_stage_data", sd(k), 32'd0);
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_rst_occ", 32'(occupancy_o), 32'd0);

    // Streaming 0x1..0x8: first output after 4 edges, then one per cycle
    begin_scn(32'h1, 32'h8);
    for (int c = 0; c <= 12; c++) begin
      drive();
      check("stream_out_valid", 32'(out_valid_o), 32'(c >= 4 && c <= 11));
      check("stream_occ", 32'(occupancy_o), 32'(c <= 4 ? c : (c <= 8 ? 4 : 12 - c)));
      finish_cycle();
    end
    check("stream_idle", 32'(idle_cnt), 32'd0);
    drain();

    // Backpressure: chain fills to 4, then stalls input with head stable
    begin_scn(32'h11, 32'h18);
    out_ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive();
      if (c < 4) begin
        check("bp_in_ready_fill", 32'(in_ready_o), 32'd1);
      end else begin
        check("bp_in_ready_full", 32'(in_ready_o), 32'd0);
        check("bp_occ", 32'(occupancy_o), 32'd4);
        check("bp_out_valid", 32'(out_valid_o), 32'd1);
        check("bp_out_data", out_data_o, 32'h11);
      end
      finish_cycle();
    end
    out_ready_i = 1'b1;
    drain();
    check("bp_idle", 32'(idle_cnt), 32'd0);

    // Stall stage 1 for one cycle in a full stream
    begin_scn(32'h21, 32'h28);
    for (int c = 0; c < 4; c++) begin
      drive();
      finish_cycle();
    end
    stall_i = 4'b0010;
    drive();
    check("stall_in_ready", 32'(in_ready_o), 32'd0);
    check("stall_out_valid", 32'(out_valid_o), 32'd1);
    check("stall_out_data", out_data_o, 32'h21);
    finish_cycle();
    stall_i = '0;
    check("stall_bubble_valid", 32'(stage_valid_o), 32'b1011);
    check("stall_bubble_occ", 32'(occupancy_o), 32'd3);
    check("stall_held_s1", sd(1), 32'h23);
    check("stall_held_s0", sd(0), 32'h24);
    drain();
    check("stall_idle", 32'(idle_cnt), 32'd1);

    // Flush stages 0/1 while stage 3 delivers and stage 0 accepts E
    begin_scn(32'h41, 32'h45);
    out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive();
      finish_cycle();
    end
    out_ready_i = 1'b1;
    flush_i     = 4'b0011;
    drive();
    check("flush_out_valid", 32'(out_valid_o), 32'd1);
    check("flush_out_data", out_data_o, 32'h41);
    check("flush_in_ready", 32'(in_ready_o), 32'd1);
    exp_q.delete(3);
    exp_q.delete(2);
    finish_cycle();
    flush_i = '0;
    check("flush_valid", 32'(stage_valid_o), 32'b1001);
    check("flush_s3", sd(3), 32'h42);
    check("flush_s0", sd(0), 32'h45);
    check("flush_occ", 32'(occupancy_o), 32'd2);
    drain();

    // Freeze for 3 cycles mid-stream, flushing stage 0 on the first
    begin_scn(32'h51, 32'h58);
    for (int c = 0; c < 5; c++) begin
      drive();
      finish_cycle();
    end
    start_i = 1'b0;
    flush_i = 4'b0001;
    drive();
    check("frz_out_valid", 32'(out_valid_o), 32'd0);
    check("frz_in_ready", 32'(in_ready_o), 32'd0);
    exp_q.delete(exp_q.size() - 1);
    finish_cycle();
    flush_i = '0;
    check("frz_valid", 32'(stage_valid_o), 32'b1110);
    check("frz_s3", sd(3), 32'h52);
    check("frz_s2", sd(2), 32'h53);
    check("frz_s1", sd(1), 32'h54);
    for (int c = 0; c < 2; c++) begin
      drive();
      check("frz_hold_out_valid", 32'(out_valid_o), 32'd0);
      check("frz_hold_in_ready", 32'(in_ready_o), 32'd0);
      finish_cycle();
      check("frz_hold_valid", 32'(stage_valid_o), 32'b1110);
      check("frz_hold_occ", 32'(occupancy_o), 32'd3);
    end
    start_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of STAGES pipeline registers that carries a WIDTH-bit payload from IF-side input to WB-side output with a valid/ready handshake.
- Supports per-stage stall with bubble insertion and per-stage flush (branch shadow kill).
- Exposes every stage's contents for forwarding/hazard logic.
- Replaces the implicit wire-through stages of the single-cycle core; the CPU top instantiates it between stage boundaries.

Parameters:
WIDTH, 32, payload bits per stage
STAGES, 4, number of register stages (>=2); stage 0 youngest, stage STAGES-1 drives output

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
start_i  in  1  global run enable; 0 freezes all transfers
in_valid_i  in  1  upstream offers payload
in_data_i  in  WIDTH  upstream payload
in_ready_o  out  1  stage 0 accepts this cycle
out_valid_o  out  1  stage STAGES-1 offers payload
out_data_o  out  WIDTH  payload of stage STAGES-1
out_ready_i  in  1  downstream accepts
stall_i  in  STAGES  bit k: stage k holds (neither accepts nor emits)
flush_i  in  STAGES  bit k: discard current contents of stage k
stage_valid_o  out  STAGES  valid bit of each stage
stage_data_o  out  STAGES*WIDTH  stage k at [k*WIDTH +: WIDTH]
occupancy_o  out  $clog2(STAGES+1)  count of valid stages

Behaviour:
- Reset: rst_i=0 at an edge clears all valid bits and data registers to 0. Reset overrides flush, stall and start_i. While rst_i=0, in_ready_o=0 and out_valid_o=0.
- Effective valid: ev[k] = valid[k] & ~flush_i[k].
- out_valid_o = start_i & ev[S-1] & ~stall_i[S-1]. take = out_valid_o & out_ready_i.
- go[S-1] = take. For k<S-1: go[k] = ev[k] & ~stall_i[k] & load[k+1].
- load[k] = start_i & ~stall_i[k] & (~ev[k] | go[k]).
- in_ready_o = load[0]. Input is accepted when in_valid_i & in_ready_o.
- Next state of stage k on load[k]:
  - k=0: valid <= in_valid_i.
  - k>0: valid <= go[k-1]; an empty or stalled upstream stage produces a bubble.
  - Data is written only when the incoming valid is 1; otherwise data holds.
- Next state of stage k without load[k]: valid <= ev[k], data holds. A flush therefore clears the valid bit even when the stage is stalled or start_i=0.
- Flush:
  - A flushed item is never delivered and never moves downstream; it becomes a bubble.
  - Flush does not affect the item arriving from upstream in the same cycle.
  - Stage 0 may accept new input in the same cycle it is flushed.
- Stall of stage k:
  - Stages <k back-pressure naturally.
  - Stage k+1 receives a bubble if it loads.
  - Stages >k continue draining.
- start_i=0: no loads, no take, in_ready_o=0, out_valid_o=0. Flush still applies. On start_i=1, operation resumes with no loss or duplication.
- Latency: an item accepted at edge t is presented on out_valid_o in the cycle after edge t+STAGES-1, i.e. STAGES register stages.
- Throughput: 1 item/cycle with no stall and out_ready_i=1. A full chain with a take accepts new input in the same cycle (full-rate pass-through, no combinational in-to-out path).
- Ordering: strictly FIFO; no duplication.
- occupancy_o = popcount(valid), registered-state based, range 0..STAGES.
- Outputs stage_valid_o and stage_data_o reflect registered state, not ev.

Test Plan:
- Reset: rst_i=0 for 2 edges with in_valid_i=1, data 0xDEAD -> stage_valid_o=0, occupancy_o=0, in_ready_o=0, out_valid_o=0; all stage_data_o=0.
- Streaming (STAGES=4): accept 0x1..0x8 back-to-back, out_ready_i=1 -> 0x1 on out after 4 edges, then one item per cycle in order; occupancy_o holds 4 in steady state.
- Backpressure: out_ready_i=0, continuous input -> after 4 accepts in_ready_o=0, occupancy_o=4, out_data_o=0x1 stable. Release out_ready_i -> 0x1..0x8 delivered in order, none lost or duplicated.
- Stall: full stream, stall_i=4'b0010 for one cycle -> stages 0/1 hold, in_ready_o=0, stage_valid_o[2]=0 next cycle. Output shows exactly one idle cycle; order preserved.
- Flush: stages 0..3 = A,B,C,D, out_ready_i=1, in_valid_i=1 with E, flush_i=4'b0011 -> D delivered; next state stage3=C, stage2=bubble, stage1=bubble, stage0=E. A and B never appear at output.
- Freeze: start_i=0 for 3 cycles mid-stream with flush_i=4'b0001 on the first -> no transfers, out_valid_o=0, stage 0 valid cleared, others unchanged. Resume -> remaining items delivered in order.
